divisor_seq: RTL and testbench

//  Parametrised sequential restoring divider: one quotient bit per clock, any WIDTH.

---
 rtl/divisor_pkg.sv | 16 +
 rtl/divisor_absneg.sv | 13 +
 rtl/divisor_seq.sv | 170 +++++++++++++++++
 tb/tb_divisor_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter width able to hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divisor_absneg.sv
// Conditional two's-complement negate; the MIN pattern maps to itself and is read
// as the unsigned magnitude 2^(WIDTH-1) by the caller.
module divisor_absneg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/divisor_seq.sv
// Sequential restoring divider, one quotient bit per clock, optional signed mode
// and divide-by-zero flag, with an init/ready handshake.
module divisor_seq
    import divisor_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] DV_in,
    input  logic [WIDTH-1:0] DR_in,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mod,
    output logic             div_zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sdv_q, sdv_d;
    logic             sq_q, sq_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             div_zero_q, div_zero_d;

    logic             neg_dv, neg_dr;
    logic [WIDTH-1:0] dv_mag, dr_mag, quo_fix, rem_fix;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH-1:0] a_sub;
    logic             ge;

    generate
        if (SIGNED_EN) begin : g_signed
            assign neg_dv = signed_op & DV_in[WIDTH-1];
            assign neg_dr = signed_op & DR_in[WIDTH-1];
        end else begin : g_unsigned
            assign neg_dv = 1'b0;
            assign neg_dr = 1'b0;
        end
    endgenerate

    divisor_absneg #(.WIDTH(WIDTH)) u_dv_mag (.val_i(DV_in), .neg_i(neg_dv), .val_o(dv_mag));
    divisor_absneg #(.WIDTH(WIDTH)) u_dr_mag (.val_i(DR_in), .neg_i(neg_dr), .val_o(dr_mag));
    divisor_absneg #(.WIDTH(WIDTH)) u_quo_fix (.val_i(quo_q), .neg_i(sq_q), .val_o(quo_fix));
    divisor_absneg #(.WIDTH(WIDTH)) u_rem_fix (.val_i(a_q), .neg_i(sdv_q), .val_o(rem_fix));

    // The partial remainder always stays below the divisor, so only the trial value
    // needs the extra bit; the difference is exact in WIDTH bits.
    assign a_shift = {a_q, dv_q[WIDTH-1]};
    assign ge      = a_shift >= {1'b0, dr_q};
    assign a_sub   = a_shift[WIDTH-1:0] - dr_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        dv_d       = dv_q;
        dr_d       = dr_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        sdv_d      = sdv_q;
        sq_d       = sq_q;
        dz_d       = dz_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        result_d   = result_q;
        mod_d      = mod_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (init) begin
                    sdv_d   = neg_dv;
                    sq_d    = neg_dv ^ neg_dr;
                    dv_d    = dv_mag;
                    dr_d    = dr_mag;
                    quo_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    if (DR_in == '0) begin
                        // Remainder path re-applies the dividend sign, giving DV_in back.
                        dz_d    = 1'b1;
                        a_d     = dv_mag;
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        a_d     = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_d   = ge ? a_sub : a_shift[WIDTH-1:0];
                dv_d  = {dv_q[WIDTH-2:0], 1'b0};
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d   = dz_q ? '1 : quo_fix;
                mod_d      = rem_fix;
                div_zero_d = dz_q;
                busy_d     = 1'b0;
                ready_d    = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            dv_q       <= '0;
            dr_q       <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            sdv_q      <= 1'b0;
            sq_q       <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
            mod_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            dv_q       <= dv_d;
            dr_q       <= dr_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            sdv_q      <= sdv_d;
            sq_q       <= sq_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
            mod_q      <= mod_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign result   = result_q;
    assign mod      = mod_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Directed bench for divisor_seq: 32-bit instance for most scenarios, 8-bit instance
// for the narrow-width case.
module tb_divisor_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0, signed_op = 1'b0;
    logic [31:0] dv_in = '0, dr_in = '0;
    logic        busy, ready, div_zero;
    logic [31:0] result, mod;

    logic        init8 = 1'b0, signed_op8 = 1'b0;
    logic [7:0]  dv_in8 = '0, dr_in8 = '0;
    logic        busy8, ready8, div_zero8;
    logic [7:0]  result8, mod8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    divisor_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .init(init), .signed_op(signed_op),
        .DV_in(dv_in), .DR_in(dr_in), .busy(busy), .ready(ready),
        .result(result), .mod(mod), .div_zero(div_zero)
    );

    divisor_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .reset(reset), .init(init8), .signed_op(signed_op8),
        .DV_in(dv_in8), .DR_in(dr_in8), .busy(busy8), .ready(ready8),
        .result(result8), .mod(mod8), .div_zero(div_zero8)
    );

    // Starts an operation once the DUT is back in IDLE and counts edges (accepting
    // edge = 1) until ready; returns -1 if ready never rises.
    task automatic do_op(input logic [31:0] dv, input logic [31:0] dr, input logic sg,
                         input int pulse_at, output int cycles);
        @(negedge clk);
        @(negedge clk);
        dv_in = dv; dr_in = dr; signed_op = sg; init = 1'b1;
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            init = (cycles == pulse_at);
            if (init) begin
                dv_in = 32'd5; dr_in = 32'd0;
            end
            if (ready) break;
        end
        init = 1'b0;
        if (!ready) cycles = -1;
    endtask

    task automatic do_op8(input logic [7:0] dv, input logic [7:0] dr, input logic sg,
                          output int cycles);
        @(negedge clk);
        @(negedge clk);
        dv_in8 = dv; dr_in8 = dr; signed_op8 = sg; init8 = 1'b1;
        cycles = 0;
        while (cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
            init8 = 1'b0;
            if (ready8) break;
        end
        if (!ready8) cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); n_fail++; end
        n_checks++;
        if (ready !== 1'b0) begin $display("FAIL reset_ready: got %b expected 0", ready); n_fail++; end
        n_checks++;
        if (result !== 32'h0 || mod !== 32'h0) begin
            $display("FAIL reset_outputs: got result=%h mod=%h expected 0 0", result, mod); n_fail++;
        end
        n_checks++;
        if (div_zero !== 1'b0 || ready8 !== 1'b0 || busy8 !== 1'b0) begin
            $display("FAIL reset_flags: got dz=%b ready8=%b busy8=%b expected 0 0 0", div_zero, ready8, busy8);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        reset = 1'b0;
        $display("reset: busy=%b ready=%b result=%h mod=%h", busy, ready, result, mod);
    endtask

    task automatic test_unsigned();
        int cyc;
        logic [31:0] dvs [3] = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFF9};
        logic [31:0] drs [3] = '{32'd7, 32'h10, 32'd2};
        logic [31:0] eq  [3] = '{32'd14, 32'h0FFFFFFF, 32'h7FFFFFFC};
        logic [31:0] er  [3] = '{32'd2, 32'hF, 32'd1};
        for (int i = 0; i < 3; i++) begin
            do_op(dvs[i], drs[i], 1'b0, -1, cyc);
            if (cyc !== 34) begin $display("FAIL unsigned_latency[%0d]: got %0d expected 34", i, cyc); n_fail++; end
            n_checks++;
            if (result !== eq[i] || mod !== er[i] || div_zero !== 1'b0) begin
                $display("FAIL unsigned[%0d]: got q=%h r=%h dz=%b expected q=%h r=%h dz=0",
                         i, result, mod, div_zero, eq[i], er[i]);
                n_fail++;
            end
            n_checks++;
            $display("unsigned %h / %h -> q=%h r=%h in %0d cycles", dvs[i], drs[i], result, mod, cyc);
        end
    endtask

    task automatic test_signed();
        int cyc;
        logic [31:0] dvs [4] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] drs [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] eq  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'h80000000};
        logic [31:0] er  [4] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0};
        for (int i = 0; i < 4; i++) begin
            do_op(dvs[i], drs[i], 1'b1, -1, cyc);
            if (result !== eq[i] || mod !== er[i] || div_zero !== 1'b0 || cyc !== 34) begin
                $display("FAIL signed[%0d]: got q=%h r=%h dz=%b cyc=%0d expected q=%h r=%h dz=0 cyc=34",
                         i, result, mod, div_zero, cyc, eq[i], er[i]);
                n_fail++;
            end
            n_checks++;
            $display("signed %h / %h -> q=%h r=%h", dvs[i], drs[i], result, mod);
        end
    endtask

    task automatic test_overflow_unsigned();
        int cyc;
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, -1, cyc);
        if (result !== 32'h0 || mod !== 32'h80000000) begin
            $display("FAIL min_unsigned: got q=%h r=%h expected q=00000000 r=80000000", result, mod);
            n_fail++;
        end
        n_checks++;
        $display("unsigned 80000000 / ffffffff -> q=%h r=%h", result, mod);
    endtask

    task automatic test_div_zero();
        int cyc;
        do_op(32'd5, 32'd0, 1'b0, -1, cyc);
        if (cyc !== 2) begin $display("FAIL dz_latency: got %0d expected 2", cyc); n_fail++; end
        n_checks++;
        if (result !== 32'hFFFFFFFF || mod !== 32'd5 || div_zero !== 1'b1) begin
            $display("FAIL dz_unsigned: got q=%h r=%h dz=%b expected q=ffffffff r=00000005 dz=1",
                     result, mod, div_zero);
            n_fail++;
        end
        n_checks++;
        $display("5 / 0 -> q=%h r=%h dz=%b in %0d cycles", result, mod, div_zero, cyc);
        do_op(32'hFFFFFFFB, 32'd0, 1'b1, -1, cyc);
        if (result !== 32'hFFFFFFFF || mod !== 32'hFFFFFFFB || div_zero !== 1'b1) begin
            $display("FAIL dz_signed: got q=%h r=%h dz=%b expected q=ffffffff r=fffffffb dz=1",
                     result, mod, div_zero);
            n_fail++;
        end
        n_checks++;
        $display("signed -5 / 0 -> q=%h r=%h dz=%b", result, mod, div_zero);
    endtask

    task automatic test_init_ignored();
        int cyc;
        do_op(32'd1000, 32'd10, 1'b0, 10, cyc);
        if (result !== 32'd100 || mod !== 32'd0 || div_zero !== 1'b0 || cyc !== 34) begin
            $display("FAIL init_ignored: got q=%h r=%h dz=%b cyc=%0d expected q=00000064 r=0 dz=0 cyc=34",
                     result, mod, div_zero, cyc);
            n_fail++;
        end
        n_checks++;
        $display("1000 / 10 with stray init -> q=%h r=%h dz=%b", result, mod, div_zero);
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic saw_low;
        @(negedge clk);
        @(negedge clk);
        dv_in = 32'd100; dr_in = 32'd7; signed_op = 1'b0; init = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) dv_in = 32'd999;
            if (ready) break;
        end
        if (cyc !== 34 || result !== 32'd14 || mod !== 32'd2) begin
            $display("FAIL b2b_first: got q=%h r=%h cyc=%0d expected q=0000000e r=2 cyc=34", result, mod, cyc);
            n_fail++;
        end
        n_checks++;
        $display("b2b first 100 / 7 -> q=%h r=%h", result, mod);
        dv_in = 32'd1000; dr_in = 32'd10;
        cyc = 0;
        saw_low = 1'b0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1 && ready !== 1'b1) begin
                $display("FAIL b2b_ready_hold: got %b expected 1", ready); n_fail++;
            end
            if (cyc == 1) n_checks++;
            if (!ready) saw_low = 1'b1;
            if (ready && saw_low) break;
        end
        init = 1'b0;
        if (cyc !== 35 || result !== 32'd100 || mod !== 32'd0) begin
            $display("FAIL b2b_second: got q=%h r=%h gap=%0d expected q=00000064 r=0 gap=35", result, mod, cyc);
            n_fail++;
        end
        n_checks++;
        $display("b2b second 1000 / 10 -> q=%h r=%h gap=%0d", result, mod, cyc);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        @(negedge clk);
        dv_in = 32'hFFFFFFFF; dr_in = 32'd3; signed_op = 1'b0; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'h0 || mod !== 32'h0) begin
            $display("FAIL mid_reset: got busy=%b ready=%b q=%h r=%h expected 0 0 0 0", busy, ready, result, mod);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL mid_reset_abort: got busy=%b ready=%b expected 0 0", busy, ready);
            n_fail++;
        end
        n_checks++;
        $display("reset mid-run -> busy=%b ready=%b q=%h", busy, ready, result);
    endtask

    task automatic test_width8();
        int cyc;
        logic [7:0] dvs [3] = '{8'd255, 8'h80, 8'h80};
        logic [7:0] drs [3] = '{8'd16, 8'hFF, 8'd3};
        logic       sgs [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] eq  [3] = '{8'd15, 8'h80, 8'hD6};
        logic [7:0] er  [3] = '{8'd15, 8'h00, 8'hFE};
        for (int i = 0; i < 3; i++) begin
            do_op8(dvs[i], drs[i], sgs[i], cyc);
            if (result8 !== eq[i] || mod8 !== er[i] || cyc !== 10) begin
                $display("FAIL w8[%0d]: got q=%h r=%h cyc=%0d expected q=%h r=%h cyc=10",
                         i, result8, mod8, cyc, eq[i], er[i]);
                n_fail++;
            end
            n_checks++;
            $display("w8 %h / %h signed=%b -> q=%h r=%h in %0d cycles", dvs[i], drs[i], sgs[i], result8, mod8, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow_unsigned();
        test_div_zero();
        test_init_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
